// File: rtl/i2c_pkg.sv
// Shared types and default widths for the byte-level I2C master controller.
package i2c_pkg;
    localparam int I2C_ADDR_W = 7;
    localparam int I2C_DATA_W = 8;
    localparam int I2C_CMD_W  = I2C_ADDR_W + 1;

    typedef enum logic [3:0] {
        READY,
        START,
        COMMAND,
        SLV_ACK1,
        WR,
        RD,
        SLV_ACK2,
        MSTR_ACK,
        STOP
    } i2c_state_e;
endpackage

// File: rtl/i2c_master_ctrl_edge_det.sv
// Turns the generator's data_clk into one-cycle rise/fall strobes in the clk domain.
module i2c_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic i_data_clk,
    output logic o_data_clk_d,
    output logic o_rise,
    output logic o_fall
);
    logic r_data_clk_d;

    always_ff @(posedge clk) begin
        if (rst) r_data_clk_d <= 1'b0;
        else     r_data_clk_d <= i_data_clk;
    end

    assign o_data_clk_d = r_data_clk_d;
    assign o_rise       =  i_data_clk & ~r_data_clk_d;
    assign o_fall       = ~i_data_clk &  r_data_clk_d;
endmodule

// File: rtl/i2c_master_ctrl.sv
// Byte-level I2C master FSM: steps one bus bit per data_clk period, drives SDA/SCL enables.
module i2c_master_ctrl
    import i2c_pkg::*;
#(
    parameter int ADDR_W = I2C_ADDR_W,
    parameter int DATA_W = I2C_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              data_clk,
    input  logic              ena,
    input  logic [ADDR_W-1:0] addr,
    input  logic              rw,
    input  logic [DATA_W-1:0] data_wr,
    input  logic              sda_in,
    output logic              sda_oe,
    output logic              scl_ena,
    output logic              busy,
    output logic [DATA_W-1:0] data_rd,
    output logic              ack_error
);
    localparam int CMD_W = ADDR_W + 1;
    // Counter indexes both the command word and data bytes, so it must cover the wider of the two.
    localparam int CNT_W = ($clog2(DATA_W) > $clog2(CMD_W)) ? $clog2(DATA_W) : $clog2(CMD_W);

    logic             w_rise, w_fall, w_dclk_d;
    logic [CMD_W-1:0] w_cmd;
    logic             w_same;

    i2c_state_e        r_state;
    logic [CMD_W-1:0]  r_cmd;
    logic [DATA_W-1:0] r_tx, r_rx;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_sda_bit;

    i2c_edge_det u_edge (
        .clk          (clk),
        .rst          (rst),
        .i_data_clk   (data_clk),
        .o_data_clk_d (w_dclk_d),
        .o_rise       (w_rise),
        .o_fall       (w_fall)
    );

    assign w_cmd  = {addr, rw};
    assign w_same = (w_cmd == r_cmd);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= READY;
            r_cmd     <= '0;
            r_tx      <= '0;
            r_rx      <= '0;
            r_cnt     <= CNT_W'(DATA_W - 1);
            r_sda_bit <= 1'b1;
            sda_oe    <= 1'b0;
            scl_ena   <= 1'b0;
            busy      <= 1'b0;
            data_rd   <= '0;
            ack_error <= 1'b0;
        end else begin
            // START/STOP move SDA while SCL is high; everywhere else SDA follows the bit register.
            case (r_state)
                START:   sda_oe <= ~w_dclk_d;
                STOP:    sda_oe <=  w_dclk_d;
                default: sda_oe <= ~r_sda_bit;
            endcase

            if (w_rise) begin
                case (r_state)
                    READY: begin
                        if (ena) begin
                            r_cmd   <= w_cmd;
                            r_tx    <= data_wr;
                            busy    <= 1'b1;
                            r_state <= START;
                        end else begin
                            busy <= 1'b0;
                        end
                    end
                    START: begin
                        busy      <= 1'b1;
                        r_sda_bit <= r_cmd[CMD_W-1];
                        r_cnt     <= CNT_W'(CMD_W - 1);
                        r_state   <= COMMAND;
                    end
                    COMMAND: begin
                        if (r_cnt == '0) begin
                            r_sda_bit <= 1'b1;
                            r_state   <= SLV_ACK1;
                        end else begin
                            r_cnt     <= r_cnt - 1'b1;
                            r_sda_bit <= r_cmd[r_cnt - 1'b1];
                        end
                    end
                    SLV_ACK1: begin
                        r_cnt <= CNT_W'(DATA_W - 1);
                        if (!r_cmd[0]) begin
                            r_sda_bit <= r_tx[DATA_W-1];
                            r_state   <= WR;
                        end else begin
                            r_sda_bit <= 1'b1;
                            r_state   <= RD;
                        end
                    end
                    WR: begin
                        busy <= 1'b1;
                        if (r_cnt == '0) begin
                            r_sda_bit <= 1'b1;
                            r_state   <= SLV_ACK2;
                        end else begin
                            r_cnt     <= r_cnt - 1'b1;
                            r_sda_bit <= r_tx[r_cnt - 1'b1];
                        end
                    end
                    RD: begin
                        busy <= 1'b1;
                        if (r_cnt == '0) begin
                            data_rd   <= r_rx;
                            // ACK only if the caller wants another byte from the same slave.
                            r_sda_bit <= ~(ena & w_same);
                            r_state   <= MSTR_ACK;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                    SLV_ACK2, MSTR_ACK: begin
                        if (ena) begin
                            busy  <= 1'b0;
                            r_cmd <= w_cmd;
                            r_tx  <= data_wr;
                            if (w_same) begin
                                r_cnt <= CNT_W'(DATA_W - 1);
                                if (!rw) begin
                                    r_sda_bit <= data_wr[DATA_W-1];
                                    r_state   <= WR;
                                end else begin
                                    r_sda_bit <= 1'b1;
                                    r_state   <= RD;
                                end
                            end else begin
                                r_state <= START;
                            end
                        end else begin
                            r_state <= STOP;
                        end
                    end
                    STOP: begin
                        busy      <= 1'b0;
                        r_sda_bit <= 1'b1;
                        r_state   <= READY;
                    end
                    default: r_state <= READY;
                endcase
            end else if (w_fall) begin
                case (r_state)
                    START: begin
                        scl_ena   <= 1'b1;
                        ack_error <= 1'b0;
                    end
                    SLV_ACK1, SLV_ACK2: begin
                        if (sda_in) ack_error <= 1'b1;
                    end
                    RD:      r_rx[r_cnt] <= sda_in;
                    STOP:    scl_ena     <= 1'b0;
                    default: ;
                endcase
            end
        end
    end
endmodule
